// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronise, group-debounce and chord-filter push-buttons into a sticky one-hot event latch
module btn_conditioner #(
    parameter int NBTN            = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NBTN-1:0] btn_raw,
    input  logic            evt_ack,
    output logic [NBTN-1:0] btn_level,
    output logic            btn_press,
    output logic [NBTN-1:0] evt_btn,
    output logic            evt_valid,
    output logic            chord_err,
    output logic            overrun
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_REL} state_t;
    state_t state, state_nxt;
    logic [NBTN-1:0] sync1, syn, cand, cand_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic done, cnt_max, one_hot, accept;
    assign cnt_max = cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
    assign one_hot = $onehot(cand);
    assign accept = done && one_hot;
    assign btn_level = ((state == HELD || state == DB_REL) && one_hot) ? cand : '0;
    always_comb begin
        state_nxt = state;
        cnt_nxt = cnt;
        cand_nxt = cand;
        done = 1'b0;
        case (state)
            IDLE: if (|syn) begin
                cand_nxt = syn;
                cnt_nxt = '0;
                state_nxt = DB_PRESS;
            end
            DB_PRESS: if (syn != cand) state_nxt = IDLE;
                else if (cnt_max) begin
                    state_nxt = HELD;
                    done = 1'b1;
                end else cnt_nxt = cnt + CNT_W'(1);
            HELD: if (syn != cand) begin
                cnt_nxt = '0;
                state_nxt = DB_REL;
            end
            DB_REL: if (syn == cand) state_nxt = HELD;
                else if (cnt_max) state_nxt = IDLE;
                else cnt_nxt = cnt + CNT_W'(1);
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            syn <= '0;
            state <= IDLE;
            cnt <= '0;
            cand <= '0;
        end else begin
            sync1 <= btn_raw;
            syn <= sync1;
            state <= state_nxt;
            cnt <= cnt_nxt;
            cand <= cand_nxt;
        end
    end
    // a press landing on the same edge as an ack wins and is not an overrun
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_press <= 1'b0;
            chord_err <= 1'b0;
            evt_btn <= '0;
            evt_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            btn_press <= accept;
            chord_err <= done && !one_hot;
            if (accept) begin
                evt_btn <= cand;
                evt_valid <= 1'b1;
                if (evt_valid && !evt_ack) overrun <= 1'b1;
            end else if (evt_ack) begin
                evt_btn <= '0;
                evt_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed scenarios plus random stimulus scored against a run-length reference model
module tb_btn_conditioner;
    localparam int D = 8;
    logic clk = 0, reset = 0, evt_ack = 0;
    logic [3:0] btn_raw = 4'b0010;
    logic [3:0] btn_level, evt_btn;
    logic btn_press, evt_valid, chord_err, overrun;
    int checks = 0, failures = 0, n_press = 0, n_chord = 0, mstep = 0;
    always #5 clk = ~clk;

    btn_conditioner #(.NBTN(4), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .evt_ack(evt_ack),
        .btn_level(btn_level), .btn_press(btn_press), .evt_btn(evt_btn),
        .evt_valid(evt_valid), .chord_err(chord_err), .overrun(overrun)
    );

    typedef struct {bit chord; logic [3:0] val; int stamp;} exp_t;
    exp_t q[$];
    exp_t e;

    // reference: a press needs D+1 equal synchronised samples, a release D+1 samples differing from it
    logic [3:0] d1, d2, s, cand, m_evt;
    bit tracking, held, m_valid, m_ovr;
    int eq, ne;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            d1 = 0; d2 = 0; cand = 0; m_evt = 0;
            tracking = 0; held = 0; m_valid = 0; m_ovr = 0; eq = 0; ne = 0;
            q.delete();
        end else begin
            mstep++;
            s = d2; d2 = d1; d1 = btn_raw;
            if (held) begin
                if (s == cand) ne = 0;
                else begin
                    ne++;
                    if (ne == D + 1) begin held = 0; tracking = 0; end
                end
                if (evt_ack) begin m_evt = 0; m_valid = 0; end
            end else if (tracking) begin
                if (s == cand) begin
                    eq++;
                    if (eq == D + 1) begin
                        held = 1; ne = 0;
                        if ($countones(cand) == 1) begin
                            if (m_valid && !evt_ack) m_ovr = 1;
                            m_evt = cand; m_valid = 1;
                            q.push_back('{chord: 0, val: cand, stamp: mstep});
                        end else begin
                            q.push_back('{chord: 1, val: 4'b0, stamp: mstep});
                            if (evt_ack) begin m_evt = 0; m_valid = 0; end
                        end
                    end else if (evt_ack) begin m_evt = 0; m_valid = 0; end
                end else begin
                    tracking = 0;
                    if (evt_ack) begin m_evt = 0; m_valid = 0; end
                end
            end else begin
                if (s != 0) begin tracking = 1; cand = s; eq = 1; end
                if (evt_ack) begin m_evt = 0; m_valid = 0; end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (btn_press) n_press++;
        if (chord_err) n_chord++;
        if (q.size() > 0 && q[0].stamp == mstep) begin
            e = q.pop_front();
            chk("pulse_kind", {btn_press, chord_err}, e.chord ? 2'b01 : 2'b10);
            if (!e.chord) chk("pulse_evt_btn", evt_btn, e.val);
        end else if (btn_press || chord_err) chk("spurious_pulse", {btn_press, chord_err}, 2'b00);
        chk("model_evt_btn", evt_btn, m_evt);
        chk("model_evt_valid", evt_valid, m_valid);
        chk("model_overrun", overrun, m_ovr);
        chk("model_btn_level", btn_level, (held && $countones(cand) == 1) ? cand : 4'b0);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 0;
        step(2);
        reset = 1;
    endtask

    int p0, c0, r;
    initial begin
        step(2);
        chk("rst_btn_level", btn_level, 0);
        chk("rst_evt", {btn_press, evt_valid, chord_err, overrun, evt_btn}, 0);
        reset = 1;
        step(10);
        chk("t1_no_press_edge10", btn_press, 0);
        step(1);
        chk("t1_press_edge11", btn_press, 1);
        chk("t1_evt_btn", evt_btn, 4'b0010);
        chk("t1_evt_valid", evt_valid, 1);
        chk("t1_btn_level", btn_level, 4'b0010);
        step(1);
        chk("t1_press_one_cycle", btn_press, 0);

        btn_raw = 0; do_reset();
        p0 = n_press;
        for (int i = 0; i < 14; i++) begin
            btn_raw = (i % 2 == 0) ? 4'b0001 : 4'b0000;
            step(3);
        end
        chk("t2_no_press_bouncing", n_press - p0, 0);
        btn_raw = 4'b0001;
        step(10);
        chk("t2_no_press_edge10", btn_press, 0);
        step(1);
        chk("t2_press_edge11", btn_press, 1);
        step(5);
        chk("t2_single_press", n_press - p0, 1);

        btn_raw = 0; do_reset();
        p0 = n_press; c0 = n_chord;
        btn_raw = 4'b0101;
        step(20);
        chk("t3_chord_once", n_chord - c0, 1);
        chk("t3_no_press", n_press - p0, 0);
        chk("t3_evt_valid", evt_valid, 0);
        chk("t3_btn_level", btn_level, 0);

        btn_raw = 0; do_reset();
        btn_raw = 4'b1000; step(15);
        btn_raw = 0; step(20);
        btn_raw = 4'b0100; step(15);
        chk("t4_evt_btn", evt_btn, 4'b0100);
        chk("t4_overrun", overrun, 1);
        evt_ack = 1; step(1); evt_ack = 0;
        chk("t4_ack_valid", evt_valid, 0);
        chk("t4_ack_evt_btn", evt_btn, 0);
        chk("t4_overrun_sticky", overrun, 1);

        btn_raw = 0; do_reset();
        btn_raw = 4'b1000; step(15);
        btn_raw = 0; step(20);
        btn_raw = 4'b0001; step(10);
        evt_ack = 1; step(1); evt_ack = 0;
        chk("t5_press", btn_press, 1);
        chk("t5_evt_btn", evt_btn, 4'b0001);
        chk("t5_evt_valid", evt_valid, 1);
        chk("t5_no_overrun", overrun, 0);

        btn_raw = 0; do_reset();
        btn_raw = 4'b0010; step(15);
        p0 = n_press;
        btn_raw = 0; step(4);
        btn_raw = 4'b0010; step(16);
        chk("t6_glitch_no_press", n_press - p0, 0);
        chk("t6_glitch_level", btn_level, 4'b0010);
        btn_raw = 0; step(20);
        btn_raw = 4'b0100; step(6);
        chk("t6_pre_reset_valid", evt_valid, 1);
        #1 reset = 0;
        #1;
        chk("t6_async_evt_valid", evt_valid, 0);
        chk("t6_async_evt_btn", evt_btn, 0);
        chk("t6_async_level", btn_level, 0);
        step(1);
        btn_raw = 0;
        step(1);
        reset = 1;

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 3);
            btn_raw = (r == 0) ? 4'b0 : (r == 3) ? 4'($urandom_range(1, 15)) : 4'(1 << $urandom_range(0, 3));
            for (int j = $urandom_range(1, 16); j > 0; j--) begin
                evt_ack = ($urandom_range(0, 7) == 0);
                step(1);
            end
        end
        evt_ack = 0; btn_raw = 0;
        step(30);
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
